// File: rtl/acq_pkg.sv
// Shared constants and types for the acquisition framer and its FIFO.
package acq_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TAG_LSB = 12;
  localparam int unsigned PAY_W   = TAG_LSB;

  localparam logic [TAG_W-1:0] TAG_HDR  = 4'hA;
  localparam logic [TAG_W-1:0] TAG_DATA = 4'h0;
  localparam logic [TAG_W-1:0] TAG_TRL  = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    CAP  = 2'd2,
    TRL  = 2'd3
  } acq_state_e;

  // Place a tag above a 12-bit payload to form one bus word.
  function automatic logic [WORD_W-1:0] make_word(input logic [TAG_W-1:0] tag,
                                                  input logic [PAY_W-1:0] payload);
    make_word = (WORD_W'(tag) << TAG_LSB) | WORD_W'(payload);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 512
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, count_after_pop;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  // Next pointers, occupancy and the word that will sit at the head next cycle.
  always_comb begin
    push_ok         = push_i && !full_q;
    pop_ok          = pop_i && valid_q;
    wr_ptr_d        = wr_ptr_q + AW'(push_ok);
    rd_ptr_d        = rd_ptr_q + AW'(pop_ok);
    count_after_pop = count_q - CW'(pop_ok);
    count_d         = count_after_pop + CW'(push_ok);
    valid_d         = (count_d != '0);
    full_d          = (count_d == CW'(DEPTH));
    dout_d          = dout_q;
    if (push_ok && (count_after_pop == '0)) begin
      dout_d = din_i;
    end else if (count_after_pop != '0) begin
      dout_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers, occupancy and registered head word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  assign full_o  = full_q;
  assign dout_o  = dout_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/acq_tx_framer.sv
// Captures a commanded number of ADC samples and frames them as header/data/trailer words for the FT writer.
module acq_tx_framer
  import acq_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADC_W  = 12,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned LEN_W  = 24
) (
  input  logic              i_ft_clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [ADC_W-1:0]  i_adc_data,
  input  logic              i_adc_valid,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [7:0]        o_frame_cnt
);

  localparam logic [PAY_W-1:0] DROP_MAX = '1;

  acq_state_e        state_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [PAY_W-1:0]  drop_cnt_q;
  logic              overflow_q;
  logic [7:0]        frame_cnt_q;
  logic              busy_q;

  logic              fifo_full;
  logic              push_c;
  logic [DATA_W-1:0] din_c;

  // Word to push this cycle, selected by the current framing phase.
  always_comb begin
    push_c = 1'b0;
    din_c  = '0;
    case (state_q)
      HDR: begin
        push_c = !fifo_full;
        din_c  = DATA_W'(make_word(TAG_HDR, PAY_W'(frame_cnt_q)));
      end
      CAP: begin
        push_c = i_adc_valid && !fifo_full;
        din_c  = DATA_W'(make_word(TAG_DATA, PAY_W'(i_adc_data)));
      end
      TRL: begin
        push_c = !fifo_full;
        din_c  = DATA_W'(make_word(TAG_TRL, drop_cnt_q));
      end
      default: begin
        push_c = 1'b0;
      end
    endcase
  end

  // Framing state machine with its sample, drop and frame counters.
  always_ff @(posedge i_ft_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            remaining_q <= i_len;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= HDR;
          end
        end
        HDR: begin
          if (!fifo_full) begin
            state_q <= (remaining_q == '0) ? TRL : CAP;
          end
        end
        CAP: begin
          // Every strobe consumes one sample slot, whether it is stored or dropped.
          if (i_adc_valid) begin
            remaining_q <= remaining_q - LEN_W'(1);
            if (fifo_full) begin
              overflow_q <= 1'b1;
              if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_q <= drop_cnt_q + PAY_W'(1);
              end
            end
            if (remaining_q == LEN_W'(1)) begin
              state_q <= TRL;
            end
          end
        end
        TRL: begin
          if (!fifo_full) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_ft_clk),
    .rst_i   (rst),
    .push_i  (push_c),
    .din_i   (din_c),
    .full_o  (fifo_full),
    .pop_i   (i_tx_ready),
    .dout_o  (o_tx_data),
    .valid_o (o_tx_valid)
  );

  assign o_busy      = busy_q;
  assign o_overflow  = overflow_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule
